collision_speed_detector: RTL and testbench



---
 rtl/collision_speed_detector_if.sv | 27 ++
 rtl/collision_speed_detector.sv | 146 ++++++++++++++
 tb/tb_collision_speed_detector.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/collision_speed_detector_if.sv
// Pixel stream, ball position and per-frame game-controller outputs of the
// collision/speed detector.
interface collision_speed_detector_if;
    logic [9:0] x_pixel;
    logic [9:0] y_pixel;
    logic       de;
    logic       is_target;
    logic       frame_tick;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic       is_ball_moving_left;
    logic       collision_detected;
    logic [9:0] estimated_speed;
    logic       game_start;

    modport master (
        output x_pixel, y_pixel, de, is_target, frame_tick,
        output ball_x, ball_y, is_ball_moving_left,
        input  collision_detected, estimated_speed, game_start
    );

    modport slave (
        input  x_pixel, y_pixel, de, is_target, frame_tick,
        input  ball_x, ball_y, is_ball_moving_left,
        output collision_detected, estimated_speed, game_start
    );
endinterface

// File: rtl/collision_speed_detector.sv
// Per-frame ball/target overlap, player edge speed and start-zone detection
// feeding the ball game controller; all outputs update at frame end.
module collision_speed_detector #(
    parameter int unsigned BALL_SIZE       = 20,
    parameter int unsigned HIT_THRESH      = 16,
    parameter int unsigned COOLDOWN_FRAMES = 8,
    parameter int unsigned START_W         = 64,
    parameter int unsigned START_FRAMES    = 30
) (
    input logic                       clk_25MHZ,
    input logic                       reset_n,
    collision_speed_detector_if.slave bus
);

    localparam int unsigned CW = $clog2(COOLDOWN_FRAMES + 1);
    localparam int unsigned RW = $clog2(START_FRAMES + 1);

    typedef enum logic {ARMED, COOLDOWN} hit_state_t;
    typedef enum logic {WAIT_EMPTY, COUNT} start_state_t;

    hit_state_t   hit_state;
    start_state_t start_state;

    logic [9:0]    box_x, box_y;
    logic [9:0]    ovl_cnt, zone_cnt;
    logic [9:0]    max_x, prev_max_x;
    logic          seen, prev_seen;
    logic [CW-1:0] cool_cnt;
    logic [RW-1:0] run;
    logic          collision_q, start_q;
    logic [9:0]    speed_q;

    logic [10:0] box_x_hi, box_y_hi;
    logic        in_box, in_zone;
    logic [9:0]  edge_diff;

    // Upper box bounds carry an extra bit so a box near x=639 does not wrap.
    always_comb begin
        box_x_hi  = {1'b0, box_x} + 11'(BALL_SIZE - 1);
        box_y_hi  = {1'b0, box_y} + 11'(BALL_SIZE - 1);
        in_box    = (bus.x_pixel >= box_x) && ({1'b0, bus.x_pixel} <= box_x_hi) &&
                    (bus.y_pixel >= box_y) && ({1'b0, bus.y_pixel} <= box_y_hi);
        in_zone   = bus.x_pixel < 10'(START_W);
        edge_diff = (max_x >= prev_max_x) ? (max_x - prev_max_x) : (prev_max_x - max_x);
    end

    // A pixel coinciding with frame_tick is dropped; frame end takes priority.
    always_ff @(posedge clk_25MHZ or negedge reset_n) begin
        if (!reset_n) begin
            box_x      <= '0;
            box_y      <= '0;
            ovl_cnt    <= '0;
            zone_cnt   <= '0;
            max_x      <= '0;
            seen       <= 1'b0;
            prev_max_x <= '0;
            prev_seen  <= 1'b0;
        end else if (bus.frame_tick) begin
            box_x      <= bus.ball_x;
            box_y      <= bus.ball_y;
            prev_max_x <= max_x;
            prev_seen  <= seen;
            ovl_cnt    <= '0;
            zone_cnt   <= '0;
            max_x      <= '0;
            seen       <= 1'b0;
        end else if (bus.de && bus.is_target) begin
            if (in_box && (ovl_cnt != '1))
                ovl_cnt <= ovl_cnt + 1'b1;
            if (in_zone && (zone_cnt != '1))
                zone_cnt <= zone_cnt + 1'b1;
            if (bus.x_pixel > max_x)
                max_x <= bus.x_pixel;
            seen <= 1'b1;
        end
    end

    always_ff @(posedge clk_25MHZ or negedge reset_n) begin
        if (!reset_n) begin
            hit_state   <= ARMED;
            cool_cnt    <= '0;
            collision_q <= 1'b0;
            speed_q     <= '0;
        end else begin
            collision_q <= 1'b0;
            if (bus.frame_tick) begin
                case (hit_state)
                    ARMED: begin
                        if ((ovl_cnt >= 10'(HIT_THRESH)) && bus.is_ball_moving_left) begin
                            collision_q <= 1'b1;
                            speed_q     <= (seen && prev_seen) ? edge_diff : '0;
                            cool_cnt    <= CW'(COOLDOWN_FRAMES - 1);
                            hit_state   <= COOLDOWN;
                        end
                    end
                    COOLDOWN: begin
                        if (cool_cnt == '0)
                            hit_state <= ARMED;
                        else
                            cool_cnt <= cool_cnt - 1'b1;
                    end
                    default: hit_state <= ARMED;
                endcase
            end
        end
    end

    always_ff @(posedge clk_25MHZ or negedge reset_n) begin
        if (!reset_n) begin
            start_state <= WAIT_EMPTY;
            run         <= '0;
            start_q     <= 1'b0;
        end else begin
            start_q <= 1'b0;
            if (bus.frame_tick) begin
                case (start_state)
                    WAIT_EMPTY: begin
                        if (zone_cnt == '0) begin
                            run         <= '0;
                            start_state <= COUNT;
                        end
                    end
                    COUNT: begin
                        if (zone_cnt >= 10'(HIT_THRESH)) begin
                            if (run == RW'(START_FRAMES - 1)) begin
                                start_q     <= 1'b1;
                                run         <= '0;
                                start_state <= WAIT_EMPTY;
                            end else begin
                                run <= run + 1'b1;
                            end
                        end else begin
                            run <= '0;
                        end
                    end
                    default: start_state <= WAIT_EMPTY;
                endcase
            end
        end
    end

    assign bus.collision_detected = collision_q;
    assign bus.game_start         = start_q;
    assign bus.estimated_speed    = speed_q;

endmodule

// File: tb/tb_collision_speed_detector.sv
// Frame-level bench for collision_speed_detector: sparse per-frame pixel lists
// are compared against a frame-summary reference model.
module tb_collision_speed_detector;
    localparam int BS = 20;
    localparam int HT = 16;
    localparam int CD = 8;
    localparam int SW = 64;
    localparam int SF = 30;

    logic clk_25MHZ = 1'b0;
    logic reset_n;
    always #20 clk_25MHZ = ~clk_25MHZ;

    collision_speed_detector_if bus();

    collision_speed_detector #(
        .BALL_SIZE(BS), .HIT_THRESH(HT), .COOLDOWN_FRAMES(CD),
        .START_W(SW), .START_FRAMES(SF)
    ) dut (
        .clk_25MHZ(clk_25MHZ),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    typedef struct { int x; int y; bit t; } pix_t;
    pix_t pq[$];

    int n_vec = 0;
    int n_err = 0;

    // Stimulus controls applied at each frame tick.
    int g_bx = 0, g_by = 0;
    bit g_left = 1'b1;
    bit g_tick_de = 1'b0;

    // Reference model state: box in force for the frame being driven etc.
    int m_bx, m_by, m_frame, m_last_hit, m_speed, m_pmax, m_run;
    bit m_pseen, m_zarm;
    bit exp_hit, exp_start;
    int exp_speed;

    logic [13:0] got, want;
    logic s1h, s1s, s2h, s2s;
    logic [9:0] spd1, spd2;

    task automatic m_reset();
        m_bx = 0; m_by = 0; m_frame = 0; m_last_hit = -100; m_speed = 0;
        m_pmax = 0; m_pseen = 0; m_zarm = 0; m_run = 0;
    endtask

    task automatic add_pix(input int x, input int y, input bit t);
        pix_t p;
        p.x = x; p.y = y; p.t = t;
        pq.push_back(p);
    endtask

    task automatic add_rect(input int x0, input int y0, input int w, input int h);
        for (int j = 0; j < h; j++)
            for (int i = 0; i < w; i++)
                add_pix(x0 + i, y0 + j, 1'b1);
    endtask

    task automatic model_frame();
        int ovl = 0, zone = 0, mx = 0;
        bit sn = 0;
        foreach (pq[i]) begin
            if (pq[i].t) begin
                if (pq[i].x >= m_bx && pq[i].x < m_bx + BS && pq[i].y >= m_by && pq[i].y < m_by + BS)
                    ovl++;
                if (pq[i].x < SW) zone++;
                if (pq[i].x > mx) mx = pq[i].x;
                sn = 1;
            end
        end
        if (ovl > 1023) ovl = 1023;
        if (zone > 1023) zone = 1023;
        exp_hit = g_left && (ovl >= HT) && (m_frame - m_last_hit > CD);
        if (exp_hit) begin
            m_last_hit = m_frame;
            m_speed = (sn && m_pseen) ? ((mx > m_pmax) ? mx - m_pmax : m_pmax - mx) : 0;
        end
        exp_start = 0;
        if (!m_zarm) begin
            if (zone == 0) begin m_zarm = 1; m_run = 0; end
        end else if (zone >= HT) begin
            m_run++;
            if (m_run == SF) begin exp_start = 1; m_zarm = 0; m_run = 0; end
        end else begin
            m_run = 0;
        end
        exp_speed = m_speed;
        m_pmax = mx; m_pseen = sn;
        m_bx = g_bx; m_by = g_by;
        m_frame++;
        want = {exp_hit, exp_start, 2'b00, 10'(exp_speed)};
    endtask

    task automatic do_frame(input bit rst_mid);
        foreach (pq[i]) begin
            @(negedge clk_25MHZ);
            bus.de = 1'b1; bus.is_target = pq[i].t;
            bus.x_pixel = 10'(pq[i].x); bus.y_pixel = 10'(pq[i].y);
        end
        @(negedge clk_25MHZ);
        bus.de = g_tick_de; bus.is_target = 1'b1;
        bus.x_pixel = 10'(m_bx); bus.y_pixel = 10'(m_by);
        bus.ball_x = 10'(g_bx); bus.ball_y = 10'(g_by);
        bus.is_ball_moving_left = g_left;
        bus.frame_tick = 1'b1;
        model_frame();
        @(posedge clk_25MHZ); #1;
        s1h = bus.collision_detected; s1s = bus.game_start; spd1 = bus.estimated_speed;
        if (rst_mid) begin
            reset_n = 1'b0;
            #1;
            bus.frame_tick = 1'b0; bus.de = 1'b0;
            m_reset();
        end else begin
            @(negedge clk_25MHZ);
            bus.frame_tick = 1'b0; bus.de = 1'b0;
            @(posedge clk_25MHZ); #1;
        end
        s2h = bus.collision_detected; s2s = bus.game_start; spd2 = bus.estimated_speed;
        got = {s1h, s1s, s2h, s2s, spd1};
        pq.delete();
    endtask

    task automatic fill(input int n, input int fx);
        for (int i = 0; i < n; i++) begin
            if (fx >= 0) add_pix(fx, 300, 1'b1);
            do_frame(1'b0);
            n_vec++;
            if (got !== want) begin n_err++; $display("FAIL fill_frame: got %h want %h", got, want); end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.x_pixel = '0; bus.y_pixel = '0; bus.de = 1'b0; bus.is_target = 1'b0;
        bus.frame_tick = 1'b0; bus.ball_x = '0; bus.ball_y = '0; bus.is_ball_moving_left = 1'b0;
        m_reset();
        repeat (3) @(posedge clk_25MHZ);
        #1;
        n_vec++;
        if (bus.collision_detected !== 1'b0) begin n_err++; $display("FAIL reset_collision: got %b want 0", bus.collision_detected); end
        n_vec++;
        if (bus.game_start !== 1'b0) begin n_err++; $display("FAIL reset_start: got %b want 0", bus.game_start); end
        n_vec++;
        if (bus.estimated_speed !== 10'd0) begin n_err++; $display("FAIL reset_speed: got %0d want 0", bus.estimated_speed); end
        @(negedge clk_25MHZ);
        reset_n = 1'b1;
    endtask

    task automatic test_hit();
        g_left = 1'b1; g_bx = 100; g_by = 80;
        fill(1, -1);
        add_rect(100, 80, 20, 20);
        do_frame(1'b0);
        n_vec++;
        if (got !== want) begin n_err++; $display("FAIL hit_frame: got %h want %h", got, want); end
        n_vec++;
        if ({s1h, s2h} !== 2'b10) begin n_err++; $display("FAIL hit_pulse: got %b want 10", {s1h, s2h}); end
    endtask

    task automatic test_speed();
        int prev_x[3] = '{200, 230, -1};
        int cur_x[3]  = '{230, 215, -1};
        int spd[3]    = '{30, 15, 0};
        for (int k = 0; k < 3; k++) begin
            fill(CD, prev_x[k]);
            add_rect(100, 80, 16, 1);
            if (cur_x[k] >= 0) add_pix(cur_x[k], 300, 1'b1);
            do_frame(1'b0);
            n_vec++;
            if (got !== want) begin n_err++; $display("FAIL speed_frame%0d: got %h want %h", k, got, want); end
            n_vec++;
            if (s1h !== 1'b1 || spd1 !== 10'(spd[k]))
                begin n_err++; $display("FAIL speed_value%0d: got hit %b speed %0d want hit 1 speed %0d", k, s1h, spd1, spd[k]); end
        end
    endtask

    task automatic test_cooldown();
        for (int pass = 0; pass < 2; pass++) begin
            g_left = (pass == 0);
            fill(CD, -1);
            for (int f = 0; f < 12; f++) begin
                add_rect(100, 80, 16, 1);
                do_frame(1'b0);
                n_vec++;
                if (got !== want) begin n_err++; $display("FAIL cooldown_frame: got %h want %h", got, want); end
                n_vec++;
                if (s1h !== (g_left && (f == 0 || f == 9)))
                    begin n_err++; $display("FAIL cooldown_pulse f%0d left %b: got %b", f, g_left, s1h); end
            end
        end
        g_left = 1'b1;
    endtask

    task automatic test_threshold();
        fill(CD, -1);
        for (int k = 0; k < 2; k++) begin
            add_rect(100, 80, 15 + k, 1);
            do_frame(1'b0);
            n_vec++;
            if (got !== want || s1h !== 1'(k))
                begin n_err++; $display("FAIL thresh_%0d: got %h want %h", 15 + k, got, want); end
        end
        g_bx = 630; g_by = 80;
        fill(CD, -1);
        add_rect(630, 80, 10, 1);
        add_rect(0, 80, 10, 1);
        do_frame(1'b0);
        n_vec++;
        if (got !== want || s1h !== 1'b0) begin n_err++; $display("FAIL edge_nowrap: got %h want %h", got, want); end
        add_rect(632, 80, 8, 2);
        do_frame(1'b0);
        n_vec++;
        if (got !== want || s1h !== 1'b1) begin n_err++; $display("FAIL edge_639: got %h want %h", got, want); end
    endtask

    // Zone frames: occ>0 gives 16 target pixels at x<64; 0 empty; -1 gives a 5-pixel gap frame.
    task automatic zone_frames(input int n, input int occ, input int pulse_at, input string name);
        for (int i = 0; i < n; i++) begin
            if (occ > 0) add_rect(0, 400, 16, 1);
            else if (occ < 0) add_rect(0, 400, 5, 1);
            do_frame(1'b0);
            n_vec++;
            if (got !== want || s1s !== (i == pulse_at))
                begin n_err++; $display("FAIL %s f%0d: got %h want %h start %b", name, i, got, want, s1s); end
        end
    endtask

    task automatic test_start();
        g_bx = 300; g_by = 200;
        zone_frames(1, 0, -1, "start_empty");
        zone_frames(SF, 1, SF - 1, "start_run");
        zone_frames(1, 0, -1, "start_empty2");
        zone_frames(15, 1, -1, "start_pre_gap");
        zone_frames(1, -1, -1, "start_gap");
        zone_frames(SF, 1, SF - 1, "start_post_gap");
    endtask

    task automatic test_random();
        for (int f = 0; f < 40; f++) begin
            int n, x, y;
            g_left = ($urandom_range(0, 3) != 0);
            g_tick_de = 1'($urandom_range(0, 1));
            n = int'($urandom_range(0, 40));
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 1) == 1) begin
                    x = m_bx + int'($urandom_range(0, 23)) - 2;
                    y = m_by + int'($urandom_range(0, 23)) - 2;
                end else begin
                    x = int'($urandom_range(0, 80));
                    y = int'($urandom_range(0, 479));
                end
                if (x < 0) x = 0;
                if (x > 639) x = 639;
                if (y < 0) y = 0;
                if (y > 479) y = 479;
                add_pix(x, y, $urandom_range(0, 4) != 0);
            end
            if ($urandom_range(0, 3) == 0) begin
                g_bx = int'($urandom_range(0, 639));
                g_by = int'($urandom_range(0, 479));
            end
            do_frame(1'b0);
            n_vec++;
            if (got !== want) begin n_err++; $display("FAIL random_f%0d: got %h want %h", f, got, want); end
        end
        g_tick_de = 1'b0; g_left = 1'b1;
    endtask

    task automatic test_reset_mid();
        g_bx = 100; g_by = 80;
        fill(CD + 1, 300);
        add_rect(100, 80, 20, 1);
        do_frame(1'b1);
        n_vec++;
        if (s1h !== 1'b1 || spd1 !== 10'd181)
            begin n_err++; $display("FAIL rstmid_before: got hit %b speed %0d want hit 1 speed 181", s1h, spd1); end
        n_vec++;
        if ({s2h, s2s, spd2} !== 12'd0)
            begin n_err++; $display("FAIL rstmid_async: got %h want 000", {s2h, s2s, spd2}); end
        repeat (2) @(negedge clk_25MHZ);
        reset_n = 1'b1;
        g_bx = 300; g_by = 200;
        add_rect(0, 0, 16, 1);
        do_frame(1'b0);
        n_vec++;
        if (got !== want || s1h !== 1'b1) begin n_err++; $display("FAIL rstmid_partial: got %h want %h", got, want); end
        zone_frames(35, 1, -1, "occupied_from_reset");
        zone_frames(1, 0, -1, "occupied_clear");
        zone_frames(SF, 1, SF - 1, "occupied_rearmed");
    endtask

    initial begin
        g_left = 1'b1;
        test_reset();
        test_hit();
        test_speed();
        test_cooldown();
        test_threshold();
        test_start();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
